// File: rtl/multi_sample_iterator.sv
//------------------------------------------------------------------------------
// multi_sample_iterator: walks a triangle's bounding box row-major, NUM_SAMPLES
// lanes per cycle. Optional MSI_SAMPLE_COUNT_EN adds a saturating sample counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multi_sample_iterator #(
  parameter int SIGFIG      = 24,
  parameter int RADIX       = 10,
  parameter int VERTS       = 3,
  parameter int AXIS        = 3,
  parameter int COLORS      = 3,
  parameter int NUM_SAMPLES = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_R13S,
  input  logic [COLORS-1:0][SIGFIG-1:0]            color_R13U,
  input  logic [1:0][1:0][SIGFIG-1:0]              box_R13S,
  input  logic                                     validTri_R13H,
  input  logic [1:0]                               ss_shift_R13U,
  output logic                                     halt_RnnnnH,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_R14S,
  output logic [COLORS-1:0][SIGFIG-1:0]            color_R14U,
  output logic [NUM_SAMPLES-1:0][1:0][SIGFIG-1:0]  sample_R14S,
  output logic [NUM_SAMPLES-1:0]                   validSamp_R14H
`ifdef MSI_SAMPLE_COUNT_EN
  ,
  output logic [31:0]                              sample_cnt_R14U
`endif
);

  localparam int W   = SIGFIG + 1;
  localparam int SHW = $clog2(RADIX + 1);

  typedef logic signed [W-1:0] ext_t;
  typedef enum logic [0:0] {S_WAIT = 1'b0, S_TEST = 1'b1} state_t;

  function automatic ext_t sext(input logic [SIGFIG-1:0] v);
    return {v[SIGFIG-1], v};
  endfunction

  state_t state, state_nxt;

  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q;
  logic [COLORS-1:0][SIGFIG-1:0]          color_q;
  logic [1:0]                             ss_q;
  ext_t                                   ll_x, ur_x, ur_y;
  ext_t                                   base_x, base_y, base_x_nxt, base_y_nxt;

  logic [SHW-1:0] shamt;
  ext_t           step, group;
  logic           accept;

  assign shamt       = SHW'(RADIX) - SHW'(ss_q);
  assign step        = ext_t'(1) << shamt;
  assign group       = ext_t'(NUM_SAMPLES) << shamt;
  assign accept      = (state == S_WAIT) && validTri_R13H;
  assign halt_RnnnnH = (state == S_TEST);

  ext_t                   lane_x [NUM_SAMPLES];
  logic [NUM_SAMPLES-1:0] lane_v;

  for (genvar k = 0; k < NUM_SAMPLES; k++) begin : g_lane
    assign lane_x[k] = base_x + (ext_t'(k) << shamt);
    assign lane_v[k] = (lane_x[k] <= ur_x);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_WAIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    base_x_nxt = base_x;
    base_y_nxt = base_y;
    case (state)
      S_WAIT: begin
        if (validTri_R13H) begin
          state_nxt  = S_TEST;
          base_x_nxt = sext(box_R13S[0][0]);
          base_y_nxt = sext(box_R13S[0][1]);
        end
      end
      S_TEST: begin
        if (base_x + group <= ur_x) begin
          base_x_nxt = base_x + group;
        end else if (base_y + step <= ur_y) begin
          base_x_nxt = ll_x;
          base_y_nxt = base_y + step;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  // Triangle context is only captured on accept, so a pending triangle cannot
  // disturb the one being iterated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tri_q   <= '0;
      color_q <= '0;
      ss_q    <= '0;
      ll_x    <= '0;
      ur_x    <= '0;
      ur_y    <= '0;
      base_x  <= '0;
      base_y  <= '0;
    end else begin
      base_x <= base_x_nxt;
      base_y <= base_y_nxt;
      if (accept) begin
        tri_q   <= tri_R13S;
        color_q <= color_R13U;
        ss_q    <= ss_shift_R13U;
        ll_x    <= sext(box_R13S[0][0]);
        ur_x    <= sext(box_R13S[1][0]);
        ur_y    <= sext(box_R13S[1][1]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tri_R14S       <= '0;
      color_R14U     <= '0;
      sample_R14S    <= '0;
      validSamp_R14H <= '0;
    end else if (state == S_TEST) begin
      tri_R14S       <= tri_q;
      color_R14U     <= color_q;
      validSamp_R14H <= lane_v;
      for (int k = 0; k < NUM_SAMPLES; k++) begin
        sample_R14S[k][0] <= lane_x[k][SIGFIG-1:0];
        sample_R14S[k][1] <= base_y[SIGFIG-1:0];
      end
    end else begin
      validSamp_R14H <= '0;
    end
  end

`ifdef MSI_SAMPLE_COUNT_EN
  logic [32:0] cnt_sum;

  always_comb begin
    cnt_sum = {1'b0, sample_cnt_R14U};
    for (int k = 0; k < NUM_SAMPLES; k++) begin
      cnt_sum = cnt_sum + 33'(validSamp_R14H[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             sample_cnt_R14U <= '0;
    else if (cnt_sum[32]) sample_cnt_R14U <= '1;
    else                 sample_cnt_R14U <= cnt_sum[31:0];
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_multi_sample_iterator.sv
//------------------------------------------------------------------------------
// tb_multi_sample_iterator: directed scoreboard bench for multi_sample_iterator.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_multi_sample_iterator;

  localparam int SF = 24;

  typedef logic [2:0][2:0][SF-1:0] tri_t;
  typedef logic [2:0][SF-1:0]      col_t;
  typedef struct packed {
    logic [SF-1:0] x0;
    logic [SF-1:0] y0;
    logic [SF-1:0] x1;
    logic [SF-1:0] y1;
    logic [1:0]    v;
    tri_t          t;
    col_t          c;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  tri_t                      tri_i = '0;
  col_t                      col_i = '0;
  logic [1:0][1:0][SF-1:0]   box_i = '0;
  logic                      vtri = 1'b0;
  logic [1:0]                ss_i = '0;
  logic                      halt;
  tri_t                      tri_o;
  col_t                      col_o;
  logic [1:0][1:0][SF-1:0]   samp_o;
  logic [1:0]                vsamp;
`ifdef MSI_SAMPLE_COUNT_EN
  logic [31:0]               cnt_o;
`endif

  multi_sample_iterator dut (
    .clk            (clk),
    .rst            (rst),
    .tri_R13S       (tri_i),
    .color_R13U     (col_i),
    .box_R13S       (box_i),
    .validTri_R13H  (vtri),
    .ss_shift_R13U  (ss_i),
    .halt_RnnnnH    (halt),
    .tri_R14S       (tri_o),
    .color_R14U     (col_o),
    .sample_R14S    (samp_o),
    .validSamp_R14H (vsamp)
`ifdef MSI_SAMPLE_COUNT_EN
    ,
    .sample_cnt_R14U(cnt_o)
`endif
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t got, e;

  // Monitor: every cycle with any lane valid must match the next expected group.
  initial forever begin
    @(negedge clk);
    if (vsamp !== 2'b00) begin
      got.x0 = samp_o[0][0]; got.y0 = samp_o[0][1];
      got.x1 = samp_o[1][0]; got.y1 = samp_o[1][1];
      got.v  = vsamp;        got.t  = tri_o;  got.c = col_o;
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL extra_group got=%h required=none", got);
      end else begin
        e = q.pop_front();
        if (got !== e) begin
          n_bad++;
          $display("FAIL group got=%h required=%h", got, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input logic [SF-1:0] x0, input logic [SF-1:0] x1, input logic [SF-1:0] y,
                      input logic [1:0] v, input tri_t t, input col_t c);
    exp_t x;
    x.x0 = x0; x.y0 = y; x.x1 = x1; x.y1 = y; x.v = v; x.t = t; x.c = c;
    q.push_back(x);
  endtask

  task automatic set_tri(input logic [SF-1:0] llx, input logic [SF-1:0] lly,
                         input logic [SF-1:0] urx, input logic [SF-1:0] ury,
                         input logic [1:0] ss, input tri_t t, input col_t c);
    tri_i = t; col_i = c; ss_i = ss;
    box_i[0][0] = llx; box_i[0][1] = lly; box_i[1][0] = urx; box_i[1][1] = ury;
  endtask

  task automatic count_halt(input string name, input int req);
    int hc;
    hc = 0;
    while (halt && hc < 64) begin
      hc++;
      @(posedge clk); #1;
    end
    check(name, 64'(hc), 64'(req));
  endtask

  // Presents a triangle for one edge; the step input is scrambled afterwards
  // to show the latched step is what gets used.
  task automatic run_tri(input logic [SF-1:0] llx, input logic [SF-1:0] lly,
                         input logic [SF-1:0] urx, input logic [SF-1:0] ury,
                         input logic [1:0] ss, input tri_t t, input col_t c,
                         input int req_halt, input string name);
    set_tri(llx, lly, urx, ury, ss, t, c);
    vtri = 1'b1;
    @(posedge clk); #1;
    vtri = 1'b0;
    ss_i = ~ss;
    count_halt(name, req_halt);
    repeat (2) @(posedge clk);
    #1;
  endtask

  tri_t ta, tb, tc;
  col_t ca, cb, cc;

  initial begin
    ta = {9{24'h000111}} ^ {24'h1, 24'h2, 24'h3, 24'h4, 24'h5, 24'h6, 24'h7, 24'h8, 24'h9};
    tb = {9{24'h00A0B0}} ^ {24'h10, 24'h20, 24'h30, 24'h40, 24'h50, 24'h60, 24'h70, 24'h80, 24'h90};
    tc = {9{24'h123456}};
    ca = {24'h0000FF, 24'h00FF00, 24'hFF0000};
    cb = {24'h000101, 24'h000202, 24'h000303};
    cc = {24'h00ABCD, 24'h00BCDE, 24'h00CDEF};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_halt",   64'(halt), 64'd0);
    check("rst_valid",  64'(vsamp), 64'd0);
    check("rst_sample", 64'(|samp_o), 64'd0);
    check("rst_tri",    64'(|tri_o), 64'd0);
    check("rst_color",  64'(|col_o), 64'd0);

    // 2x2 groups over (0,0)-(2048,1024) at step 1024
    push(24'd0,    24'd1024, 24'd0,    2'b11, ta, ca);
    push(24'd2048, 24'd3072, 24'd0,    2'b01, ta, ca);
    push(24'd0,    24'd1024, 24'd1024, 2'b11, ta, ca);
    push(24'd2048, 24'd3072, 24'd1024, 2'b01, ta, ca);
    run_tri(24'd0, 24'd0, 24'd2048, 24'd1024, 2'd0, ta, ca, 4, "halt_box2x1");
`ifdef MSI_SAMPLE_COUNT_EN
    check("sample_cnt", 64'(cnt_o), 64'd6);
`endif

    // Degenerate box
    push(24'd512, 24'd1536, 24'd512, 2'b01, tb, cb);
    run_tri(24'd512, 24'd512, 24'd512, 24'd512, 2'd0, tb, cb, 1, "halt_point");

    // Half-pixel step
    push(24'd0, 24'd512, 24'd0, 2'b11, tc, cc);
    run_tri(24'd0, 24'd0, 24'd512, 24'd0, 2'd1, tc, cc, 1, "halt_ss1");

    // Right screen edge: lane 1 wraps in SIGFIG bits but must be invalid
    push(24'h7FFC00, 24'h800000, 24'd0, 2'b01, ta, cb);
    run_tri(24'h7FFC00, 24'd0, 24'h7FFC00, 24'd0, 2'd0, ta, cb, 1, "halt_edge");

    // Negative coordinates
    push(24'hFFFC00, 24'd0, 24'hFFFC00, 2'b11, tb, ca);
    run_tri(24'hFFFC00, 24'hFFFC00, 24'd0, 24'hFFFC00, 2'd0, tb, ca, 1, "halt_neg");

    // Second triangle held valid during TEST: waits, then accepted once
    push(24'd0,    24'd1024, 24'd0,    2'b11, ta, ca);
    push(24'd2048, 24'd3072, 24'd0,    2'b01, ta, ca);
    push(24'd0,    24'd1024, 24'd1024, 2'b11, ta, ca);
    push(24'd2048, 24'd3072, 24'd1024, 2'b01, ta, ca);
    push(24'd512,  24'd1536, 24'd512,  2'b01, tb, cb);
    set_tri(24'd0, 24'd0, 24'd2048, 24'd1024, 2'd0, ta, ca);
    vtri = 1'b1;
    @(posedge clk); #1;
    set_tri(24'd512, 24'd512, 24'd512, 24'd512, 2'd0, tb, cb);
    count_halt("halt_b2b_first", 4);
    check("b2b_bubble", 64'(halt), 64'd0);
    @(posedge clk); #1;
    vtri = 1'b0;
    check("b2b_accept", 64'(halt), 64'd1);
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset during TEST
    push(24'd0, 24'd1024, 24'd0, 2'b11, ta, ca);
    set_tri(24'd0, 24'd0, 24'd2048, 24'd1024, 2'd0, ta, ca);
    vtri = 1'b1;
    @(posedge clk); #1;
    vtri = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_valid",  64'(vsamp), 64'd0);
    check("midrst_halt",   64'(halt), 64'd0);
    check("midrst_sample", 64'(|samp_o), 64'd0);
    check("midrst_tri",    64'(|tri_o), 64'd0);
`ifdef MSI_SAMPLE_COUNT_EN
    check("midrst_cnt", 64'(cnt_o), 64'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    push(24'd0, 24'd512, 24'd0, 2'b11, tc, cc);
    run_tri(24'd0, 24'd0, 24'd512, 24'd0, 2'd1, tc, cc, 1, "halt_after_rst");

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_sample_iterator.md
Name: multi_sample_iterator

Overview:
- Raster stage directly upstream of the multi-sample sample test; sits after bounding-box generation.
- Accepts one triangle plus its bounding box, then walks the box in row-major order at the subsample step.
- Emits NUM_SAMPLES horizontally adjacent sample locations per cycle, with one valid flag per lane.
- Stalls the upstream stage with a halt signal while iterating.

Parameters:
- SIGFIG, 24, bits in position and colour words (signed fixed point)
- RADIX, 10, fraction bits
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex (x,y,z)
- COLORS, 3, colour channels
- NUM_SAMPLES, 2, sample lanes per cycle (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, asynchronous, active-high
- tri_R13S  in  [VERTS][AXIS]xSIGFIG signed  triangle vertices
- color_R13U  in  [COLORS]xSIGFIG  triangle colour
- box_R13S  in  [2][2]xSIGFIG signed  [0]=lower-left (x,y), [1]=upper-right (x,y); grid-aligned, ll<=ur
- validTri_R13H  in  1  triangle/box valid
- ss_shift_R13U  in  2  subsample step = 1<<(RADIX-ss_shift); legal values 0..3
- halt_RnnnnH  out  1  high = upstream must hold its data
- tri_R14S  out  [VERTS][AXIS]xSIGFIG  latched triangle
- color_R14U  out  [COLORS]xSIGFIG  latched colour
- sample_R14S  out  [NUM_SAMPLES][2]xSIGFIG  per-lane sample (x,y)
- validSamp_R14H  out  NUM_SAMPLES  per-lane valid

Behaviour:
- States: WAIT and TEST. Reset gives state=WAIT and clears all outputs: validSamp=0, halt=0, samples/tri/colour=0.
- halt_RnnnnH is driven directly from the state register: 1 in TEST, 0 in WAIT.
- Accept: in WAIT with validTri_R13H=1, the block latches tri, colour, box and step. It sets base=(ll.x, ll.y) and moves to TEST.
- validTri_R13H while halt=1 is ignored; nothing is latched.
- In TEST, every cycle (registered outputs, visible the next edge):
  - lane k: x = base.x + k*step, y = base.y
  - validSamp[k] = (x <= ur.x)
  - tri and colour hold the latched values.
- Latency: first samples appear on the cycle after the accept edge.
- Advance from TEST:
  - if base.x + NUM_SAMPLES*step <= ur.x: base.x += NUM_SAMPLES*step
  - else if base.y + step <= ur.y: base.x = ll.x, base.y += step
  - else: go to WAIT (last group was emitted this cycle).
- In WAIT, validSamp=0; sample/tri/colour outputs hold their last values.
- Width rule: all comparisons and additions use SIGFIG+1 signed bits, so no wrap occurs at the screen edge. Lane offsets come from constant shifts; no multipliers.
- Degenerate box ll==ur: exactly one TEST cycle, only lane 0 valid.
- Back-to-back triangles: one WAIT cycle (bubble) between them is required and acceptable.
- Reset mid-TEST: asynchronous clear to WAIT. The in-flight triangle is dropped and validSamp=0 immediately.
- ss_shift changes while in TEST have no effect; the latched step is used.

Optional Feature:
- Macro: MSI_SAMPLE_COUNT_EN
- With the macro defined:
  - extra output sample_cnt_R14U (32 bits, unsigned).
  - It increments by popcount(validSamp_R14H) each cycle and saturates at 2^32-1.
  - It is cleared by rst.
- Without it: the port and counter are absent, and the behaviour is otherwise identical.

Test Plan:
- RADIX=10, NUM_SAMPLES=2, ss_shift=0, box (0,0)-(2048,1024):
  - cycle 1: x=0,1024, y=0, valid=11
  - cycle 2: x=2048,3072, y=0, valid=01
  - cycles 3-4 repeat at y=1024
  - halt=1 for 4 cycles, then 0.
- Box (512,512)-(512,512): one TEST cycle, lanes x=512,1536, valid=01; halt high for 1 cycle.
- ss_shift=1 (step 512), box (0,0)-(512,0): one cycle, x=0,512, valid=11.
- Second validTri presented during TEST with a different box: ignored until halt=0, then accepted. First-triangle samples are not corrupted.
- rst asserted on cycle 2 of the first scenario: validSamp=0 and halt=0 immediately. A new triangle is accepted the cycle after rst deasserts.
- With MSI_SAMPLE_COUNT_EN, run the first scenario: sample_cnt_R14U=6 afterwards; 0 after rst.
